// File: rtl/mem_wb_multi_pkg.sv
// Shared types and capture-time sanitising for the multi-lane MEM->WB register.
package mem_wb_pkg;

    localparam int unsigned LANES_MAX      = 4;
    localparam int unsigned DATA_W_MAX     = 64;
    localparam int unsigned REG_ADDR_W_MAX = 8;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_MAX-1:0] wd;
        logic                      wreg;
        logic [DATA_W_MAX-1:0]     wdata;
        logic                      LLbit_we;
        logic                      LLbit_value;
        logic [DATA_W_MAX-1:0]     pc;
        logic [DATA_W_MAX-1:0]     instr;
    } mem_wb_lane_t;

    typedef mem_wb_lane_t [LANES_MAX-1:0] mem_wb_bundle_t;

    // Younger (higher-index) lane wins both register and LLbit write conflicts.
    function automatic mem_wb_bundle_t sanitise_bundle(input mem_wb_bundle_t b);
        mem_wb_bundle_t r;
        r = b;
        for (int unsigned i = 0; i < LANES_MAX; i++) begin
            r[i].wreg     = b[i].wreg & b[i].valid & (b[i].wd != '0);
            r[i].LLbit_we = b[i].LLbit_we & b[i].valid;
        end
        for (int unsigned i = 0; i < LANES_MAX; i++) begin
            for (int unsigned j = i + 1; j < LANES_MAX; j++) begin
                if (r[j].wreg && (r[j].wd == r[i].wd)) r[i].wreg = 1'b0;
                if (r[j].LLbit_we) r[i].LLbit_we = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_wb_multi_if.sv
// MEM->WB bundle bus; slave is the pipeline register, master the surrounding stages.
// Debug commit signals exist only with MEM_WB_DEBUG_COMMIT_EN defined.
interface mem_wb_multi_if #(
    parameter int unsigned LANES      = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic                                mem_valid;
    logic                                mem_ready;
    logic [LANES-1:0]                    mem_lane_valid;
    logic [LANES-1:0][REG_ADDR_W-1:0]    mem_wd;
    logic [LANES-1:0]                    mem_wreg;
    logic [LANES-1:0][DATA_W-1:0]        mem_wdata;
    logic [LANES-1:0]                    mem_LLbit_we;
    logic [LANES-1:0]                    mem_LLbit_value;

    logic                                wb_valid;
    logic                                wb_ready;
    logic [LANES-1:0][REG_ADDR_W-1:0]    wb_wd;
    logic [LANES-1:0]                    wb_wreg;
    logic [LANES-1:0][DATA_W-1:0]        wb_wdata;
    logic [LANES-1:0]                    wb_LLbit_we;
    logic [LANES-1:0]                    wb_LLbit_value;

`ifdef MEM_WB_DEBUG_COMMIT_EN
    logic [LANES-1:0][DATA_W-1:0]        mem_inst_pc;
    logic [LANES-1:0][DATA_W-1:0]        mem_instr;
    logic [LANES-1:0]                    debug_commit_valid;
    logic [LANES-1:0][DATA_W-1:0]        debug_commit_pc;
    logic [LANES-1:0][DATA_W-1:0]        debug_commit_instr;
    logic [CNT_W-1:0]                    debug_commit_cnt;
`endif

    modport slave (
`ifdef MEM_WB_DEBUG_COMMIT_EN
        input  mem_inst_pc, mem_instr,
        output debug_commit_valid, debug_commit_pc, debug_commit_instr, debug_commit_cnt,
`endif
        input  mem_valid, mem_lane_valid, mem_wd, mem_wreg, mem_wdata,
               mem_LLbit_we, mem_LLbit_value, wb_ready,
        output mem_ready, wb_valid, wb_wd, wb_wreg, wb_wdata, wb_LLbit_we, wb_LLbit_value
    );

    modport master (
`ifdef MEM_WB_DEBUG_COMMIT_EN
        output mem_inst_pc, mem_instr,
        input  debug_commit_valid, debug_commit_pc, debug_commit_instr, debug_commit_cnt,
`endif
        output mem_valid, mem_lane_valid, mem_wd, mem_wreg, mem_wdata,
               mem_LLbit_we, mem_LLbit_value, wb_ready,
        input  mem_ready, wb_valid, wb_wd, wb_wreg, wb_wdata, wb_LLbit_we, wb_LLbit_value
    );

endinterface

// File: rtl/mem_wb_multi_skid.sv
// Generic two-entry valid/ready skid buffer (output entry O + skid entry S) with
// synchronous flush; in_ready_o is a pure flop output.
module pipe_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         o_valid_q, o_valid_d;
    logic         s_valid_q, s_valid_d;
    logic [W-1:0] o_data_q,  o_data_d;
    logic [W-1:0] s_data_q,  s_data_d;
    logic         accept, o_load;

    assign in_ready_o  = !s_valid_q;
    assign out_valid_o = o_valid_q;
    assign out_data_o  = o_data_q;
    assign accept      = in_valid_i && !s_valid_q;
    assign o_load      = !o_valid_q || out_ready_i;

    always_comb begin
        o_valid_d = o_valid_q;
        s_valid_d = s_valid_q;
        o_data_d  = o_data_q;
        s_data_d  = s_data_q;
        if (flush_i) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            // S always drains into O before new input, keeping strict FIFO order.
            if (o_load) begin
                if (s_valid_q) begin
                    o_valid_d = 1'b1;
                    o_data_d  = s_data_q;
                    s_valid_d = 1'b0;
                end else if (accept) begin
                    o_valid_d = 1'b1;
                    o_data_d  = in_data_i;
                end else begin
                    o_valid_d = 1'b0;
                end
            end
            if (accept && !o_load) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            s_valid_q <= s_valid_d;
            o_data_q  <= o_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM->WB pipeline register: sanitises each bundle on capture and buffers
// it in a skid buffer. MEM_WB_DEBUG_COMMIT_EN adds the difftest commit ports and counter.
module mem_wb_multi
    import mem_wb_pkg::*;
#(
    parameter int unsigned LANES      = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    mem_wb_multi_if.slave  bus
);
    typedef struct packed {
`ifdef MEM_WB_DEBUG_COMMIT_EN
        logic                  valid;
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     instr;
`endif
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic                  ll_we;
        logic                  ll_value;
    } lane_t;

    typedef lane_t [LANES-1:0] payload_t;
    localparam int unsigned PW = $bits(payload_t);

    mem_wb_bundle_t raw, san;
    payload_t       in_pl, out_pl;
    logic           out_valid;
    logic           unused_san;

    // Widen into the package's max-width bundle so one sanitiser serves all configs.
    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            raw[i].valid                 = bus.mem_lane_valid[i];
            raw[i].wd[REG_ADDR_W-1:0]    = bus.mem_wd[i];
            raw[i].wreg                  = bus.mem_wreg[i];
            raw[i].wdata[DATA_W-1:0]     = bus.mem_wdata[i];
            raw[i].LLbit_we              = bus.mem_LLbit_we[i];
            raw[i].LLbit_value           = bus.mem_LLbit_value[i];
`ifdef MEM_WB_DEBUG_COMMIT_EN
            raw[i].pc[DATA_W-1:0]        = bus.mem_inst_pc[i];
            raw[i].instr[DATA_W-1:0]     = bus.mem_instr[i];
`endif
        end
    end

    assign san        = sanitise_bundle(raw);
    assign unused_san = ^san;

    always_comb begin
        in_pl = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            in_pl[i].wd       = san[i].wd[REG_ADDR_W-1:0];
            in_pl[i].wreg     = san[i].wreg;
            in_pl[i].wdata    = san[i].wdata[DATA_W-1:0];
            in_pl[i].ll_we    = san[i].LLbit_we;
            in_pl[i].ll_value = san[i].LLbit_value;
`ifdef MEM_WB_DEBUG_COMMIT_EN
            in_pl[i].valid    = san[i].valid;
            in_pl[i].pc       = san[i].pc[DATA_W-1:0];
            in_pl[i].instr    = san[i].instr[DATA_W-1:0];
`endif
        end
    end

    pipe_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst),
        .flush_i     (flush),
        .in_valid_i  (bus.mem_valid),
        .in_ready_o  (bus.mem_ready),
        .in_data_i   (in_pl),
        .out_valid_o (out_valid),
        .out_ready_i (bus.wb_ready),
        .out_data_o  (out_pl)
    );

    assign bus.wb_valid = out_valid;

    always_comb begin
        bus.wb_wd          = '0;
        bus.wb_wreg        = '0;
        bus.wb_wdata       = '0;
        bus.wb_LLbit_we    = '0;
        bus.wb_LLbit_value = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            bus.wb_wd[i]          = out_pl[i].wd;
            bus.wb_wreg[i]        = out_pl[i].wreg & out_valid;
            bus.wb_wdata[i]       = out_pl[i].wdata;
            bus.wb_LLbit_we[i]    = out_pl[i].ll_we & out_valid;
            bus.wb_LLbit_value[i] = out_pl[i].ll_value;
        end
    end

`ifdef MEM_WB_DEBUG_COMMIT_EN
    logic             drain;
    logic [CNT_W-1:0] cnt_q, cnt_d, retired;

    assign drain = out_valid && bus.wb_ready;

    always_comb begin
        bus.debug_commit_valid = '0;
        bus.debug_commit_pc    = '0;
        bus.debug_commit_instr = '0;
        retired                = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            bus.debug_commit_valid[i] = out_pl[i].valid & out_valid;
            bus.debug_commit_pc[i]    = out_pl[i].pc;
            bus.debug_commit_instr[i] = out_pl[i].instr;
            retired                   = retired + CNT_W'(out_pl[i].valid);
        end
        cnt_d = drain ? cnt_q + retired : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bus.debug_commit_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_multi.sv
// Self-checking bench for mem_wb_multi: vector table, directed corner sequences and
// a scoreboard fed at accept time and consumed at drain time.
module tb_mem_wb_multi;
    localparam int unsigned L  = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    mem_wb_multi_if #(.LANES(L), .DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    mem_wb_multi #(.LANES(L), .DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic [L-1:0]          lv;
        logic [L-1:0][AW-1:0]  wd;
        logic [L-1:0]          wreg;
        logic [L-1:0][DW-1:0]  wdata;
        logic [L-1:0]          llwe;
        logic [L-1:0]          llv;
        logic [L-1:0][DW-1:0]  pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [CW-1:0] exp_cnt = '0;

    // Reference sanitiser: scan from the youngest lane down, tracking what it kept.
    function automatic exp_t model();
        exp_t e;
        logic keep;
        logic ll_done;
        e.lv    = bus.mem_lane_valid;
        e.wd    = bus.mem_wd;
        e.wdata = bus.mem_wdata;
        e.llv   = bus.mem_LLbit_value;
        e.wreg  = '0;
        e.llwe  = '0;
        e.pc    = '0;
`ifdef MEM_WB_DEBUG_COMMIT_EN
        e.pc    = bus.mem_inst_pc;
`endif
        ll_done = 1'b0;
        for (int i = L - 1; i >= 0; i--) begin
            keep = e.lv[i] && bus.mem_wreg[i] && (e.wd[i] != '0);
            for (int j = i + 1; j < L; j++)
                if (e.wreg[j] && (e.wd[j] == e.wd[i])) keep = 1'b0;
            e.wreg[i] = keep;
            if (e.lv[i] && bus.mem_LLbit_we[i] && !ll_done) begin
                e.llwe[i] = 1'b1;
                ll_done   = 1'b1;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            if (!bus.wb_valid) begin
                check("gate_wreg", bus.wb_wreg, 0);
                check("gate_llwe", bus.wb_LLbit_we, 0);
`ifdef MEM_WB_DEBUG_COMMIT_EN
                check("gate_dbg_valid", bus.debug_commit_valid, 0);
`endif
            end
            if (bus.wb_valid && bus.wb_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got wdata %0h expected no bundle", bus.wb_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_wd",    bus.wb_wd,          mon_e.wd);
                    check("sb_wreg",  bus.wb_wreg,        mon_e.wreg);
                    check("sb_wdata", bus.wb_wdata,       mon_e.wdata);
                    check("sb_llwe",  bus.wb_LLbit_we,    mon_e.llwe);
                    check("sb_llv",   bus.wb_LLbit_value, mon_e.llv);
`ifdef MEM_WB_DEBUG_COMMIT_EN
                    check("sb_dbg_valid", bus.debug_commit_valid, mon_e.lv);
                    check("sb_dbg_pc",    bus.debug_commit_pc,    mon_e.pc);
                    exp_cnt = exp_cnt + CW'($countones(mon_e.lv));
`endif
                end
            end
            if (flush) sb.delete();
            else if (bus.mem_valid && bus.mem_ready) sb.push_back(model());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [L-1:0] lv, input logic [AW-1:0] wd1, input logic [AW-1:0] wd0,
                       input logic [L-1:0] wreg, input logic [L-1:0] llwe, input logic [L-1:0] llv,
                       input logic [DW-1:0] tag);
        bus.mem_lane_valid  = lv;
        bus.mem_wd          = {wd1, wd0};
        bus.mem_wreg        = wreg;
        bus.mem_wdata       = {tag ^ 32'h5555_0000, tag};
        bus.mem_LLbit_we    = llwe;
        bus.mem_LLbit_value = llv;
`ifdef MEM_WB_DEBUG_COMMIT_EN
        bus.mem_inst_pc     = {tag + 32'd4, tag};
        bus.mem_instr       = ~{tag + 32'd4, tag};
`endif
    endtask

    task automatic put_rand(input logic [DW-1:0] tag);
        put(L'($urandom), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            L'($urandom), L'($urandom), L'($urandom), tag);
    endtask

    typedef struct packed {
        logic [1:0] lv;
        logic [4:0] wd1, wd0;
        logic [1:0] wreg, llwe, exp_wreg, exp_llwe;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b11, 5'd3, 5'd3, 2'b11, 2'b00, 2'b10, 2'b00};
        vecs[1] = '{2'b11, 5'd7, 5'd0, 2'b11, 2'b00, 2'b10, 2'b00};
        vecs[2] = '{2'b01, 5'd5, 5'd4, 2'b11, 2'b00, 2'b01, 2'b00};
        vecs[3] = '{2'b11, 5'd5, 5'd4, 2'b11, 2'b11, 2'b11, 2'b10};
        vecs[4] = '{2'b11, 5'd6, 5'd6, 2'b01, 2'b01, 2'b01, 2'b01};
        vecs[5] = '{2'b10, 5'd6, 5'd6, 2'b11, 2'b11, 2'b10, 2'b10};
        vecs[6] = '{2'b01, 5'd9, 5'd9, 2'b11, 2'b11, 2'b01, 2'b01};
        vecs[7] = '{2'b11, 5'd0, 5'd0, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[8] = '{2'b00, 5'd2, 5'd1, 2'b11, 2'b11, 2'b00, 2'b00};

        rst = 1'b1; flush = 1'b0; bus.mem_valid = 1'b0; bus.wb_ready = 1'b0;
        put('0, '0, '0, '0, '0, '0, '0);
        #2 rst = 1'b0;
        #1;
        check("rst_wb_valid",  bus.wb_valid,  0);
        check("rst_mem_ready", bus.mem_ready, 1);
        check("rst_wb_wdata",  bus.wb_wdata,  0);
        check("rst_wb_wd",     bus.wb_wd,     0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // Vector table: accept, inspect one cycle later, drain.
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            put(vecs[k].lv, vecs[k].wd1, vecs[k].wd0, vecs[k].wreg, vecs[k].llwe, 2'b10, 32'h100 + k);
            bus.mem_valid = 1'b1;
            tick();
            bus.mem_valid = 1'b0;
            check($sformatf("vec%0d_valid", k), bus.wb_valid, 1);
            check($sformatf("vec%0d_wreg", k),  bus.wb_wreg, vecs[k].exp_wreg);
            check($sformatf("vec%0d_llwe", k),  bus.wb_LLbit_we, vecs[k].exp_llwe);
            if (k == 0) check("vec0_wd1", bus.wb_wd[1], 3);
            tick();
        end
        check("vec_idle", bus.wb_valid, 0);

        // Back-pressure: A in O, B in S, C held upstream, then A,B,C back to back.
        bus.wb_ready = 1'b0;
        put(2'b11, 5'd1, 5'd2, 2'b11, 2'b00, 2'b00, 32'hA0);
        bus.mem_valid = 1'b1;
        tick();
        check("bp_A_in_O",     bus.wb_wdata[0], 32'hA0);
        check("bp_ready_c1",   bus.mem_ready, 1);
        put(2'b11, 5'd3, 5'd4, 2'b11, 2'b00, 2'b00, 32'hB0);
        tick();
        check("bp_ready_c2",   bus.mem_ready, 0);
        check("bp_A_hold",     bus.wb_wdata[0], 32'hA0);
        put(2'b11, 5'd5, 5'd6, 2'b11, 2'b00, 2'b00, 32'hC0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_ready_low", bus.mem_ready, 0);
            check("bp_A_stall",   bus.wb_wdata[0], 32'hA0);
        end
        bus.wb_ready = 1'b1;
        tick();
        check("bp_B_next",     bus.wb_wdata[0], 32'hB0);
        check("bp_ready_rise", bus.mem_ready, 1);
        tick();
        check("bp_C_next",     bus.wb_wdata[0], 32'hC0);
        check("bp_C_valid",    bus.wb_valid, 1);
        bus.mem_valid = 1'b0;
        tick();
        check("bp_empty",      bus.wb_valid, 0);

        // Flush with both entries full and MEM offering a bundle.
        bus.wb_ready = 1'b0;
        put(2'b11, 5'd1, 5'd1, 2'b11, 2'b00, 2'b00, 32'hD0);
        bus.mem_valid = 1'b1;
        tick();
        put(2'b11, 5'd2, 5'd2, 2'b11, 2'b00, 2'b00, 32'hE0);
        tick();
        check("fl_full", bus.mem_ready, 0);
        put(2'b11, 5'd3, 5'd3, 2'b11, 2'b00, 2'b00, 32'hF0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.mem_valid = 1'b0;
        check("fl_wb_valid",  bus.wb_valid, 0);
        check("fl_mem_ready", bus.mem_ready, 1);
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("fl_nothing", bus.wb_valid, 0);
        end

        // Asynchronous reset mid-stream.
        bus.wb_ready = 1'b0;
        put(2'b11, 5'd7, 5'd8, 2'b11, 2'b11, 2'b11, 32'h1230);
        bus.mem_valid = 1'b1;
        tick();
        put(2'b11, 5'd9, 5'd10, 2'b11, 2'b11, 2'b11, 32'h4560);
        tick();
        bus.mem_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("ar_wb_valid",  bus.wb_valid, 0);
        check("ar_mem_ready", bus.mem_ready, 1);
        check("ar_wb_wdata",  bus.wb_wdata, 0);
        check("ar_wb_wd",     bus.wb_wd, 0);
        check("ar_wb_llv",    bus.wb_LLbit_value, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        put(2'b11, 5'd11, 5'd12, 2'b11, 2'b00, 2'b00, 32'h7890);
        bus.mem_valid = 1'b1;
        bus.wb_ready  = 1'b1;
        tick();
        bus.mem_valid = 1'b0;
        check("ar_first_valid", bus.wb_valid, 1);
        check("ar_first_data",  bus.wb_wdata[0], 32'h7890);
        tick();

`ifdef MEM_WB_DEBUG_COMMIT_EN
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("cnt_reset", bus.debug_commit_cnt, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            put(2'b11, 5'd1, 5'd2, 2'b11, 2'b00, 2'b00, 32'h900 + k);
            bus.mem_valid = 1'b1;
            tick();
        end
        bus.mem_valid = 1'b0;
        tick();
        check("cnt_wrap", bus.debug_commit_cnt, 4);
`endif

        // Full-rate streaming with continuous wb_ready.
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            put_rand(32'h2000 + k);
            bus.mem_valid = 1'b1;
            tick();
            check("st_valid", bus.wb_valid, 1);
            check("st_ready", bus.mem_ready, 1);
        end
        bus.mem_valid = 1'b0;
        tick();

        // Random traffic against the scoreboard, then a bounded drain.
        for (int k = 0; k < 60; k++) begin
            put_rand(32'h3000 + k);
            bus.mem_valid = ($urandom_range(0, 3) != 0);
            bus.wb_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.mem_valid = 1'b0;
        bus.wb_ready  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (sb.size() != 0 || bus.wb_valid) tick();
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_idle",     bus.wb_valid, 0);
`ifdef MEM_WB_DEBUG_COMMIT_EN
        check("cnt_model", bus.debug_commit_cnt, exp_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
